mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage data-memory access controller for the 5-stage RISC-V pipeline.
- Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Drives a variable-latency req/ack data-memory port and produces byte/half/word store lanes.
- Returns aligned, sign/zero-extended load data to MEM/WB, and raises a stall while the access is outstanding.

Parameters:
- ADDR_W, 32, data-memory byte-address width; addr_in[1:0] selects the byte lane.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- mem_rd_in  input  1  load in MEM stage (from EX/MEM).
- mem_wr_in  input  1  store in MEM stage; never asserted together with mem_rd_in.
- dmtype_in  input  3  width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use only 000/001/010.
- addr_in  input  ADDR_W  effective address (ALU result).
- wdata_in  input  32  store data (rs2 value).
- flush  input  1  discard the current MEM-stage instruction.
- dm_req  output  1  memory request, registered.
- dm_we  output  1  write enable, registered.
- dm_addr  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}), registered.
- dm_wdata  output  32  lane-replicated store data, registered.
- dm_be  output  4  byte enables, registered.
- dm_ack  input  1  memory completion; dm_rdata is valid in the same cycle.
- dm_rdata  input  32  raw read word.
- read_data_out  output  32  extended load result, to MEM/WB read_data_in.
- mem_busy  output  1  stall request for PC/IF-ID/ID-EX/EX-MEM; holds MEM/WB as bubble.
- misalign  output  1  one-cycle misaligned-access flag.

Behaviour:
- Reset values (async): state=IDLE; dm_req, dm_we, misalign = 0; dm_addr, dm_wdata, read_data_out = 0; dm_be = 0000.
- Alignment check:
  - H/HU misaligned when addr[0]=1.
  - W misaligned when addr[1:0]≠00.
  - B/BU never misaligned.
- States: IDLE, WAIT, DONE, DRAIN.
- IDLE:
  - Access (rd|wr), aligned, flush=0:
    - Latch dm_req=1, dm_we=mem_wr_in, dm_addr, dm_be, dm_wdata.
    - Go to WAIT.
    - mem_busy=1 combinationally this cycle.
  - Access misaligned, flush=0:
    - No request; misalign=1 for the next cycle; read_data_out=0; stay IDLE; mem_busy=0.
  - flush=1 or no access: stay IDLE.
- WAIT:
  - mem_busy=1; dm_req and all latched outputs held stable.
  - dm_ack=1 and flush=0: drop dm_req/dm_we; load result → read_data_out (stores write 0); go to DONE.
  - flush=1 and dm_ack=0: go to DRAIN (request cannot be retracted).
  - flush=1 and dm_ack=1: drop dm_req; read_data_out=0; go to IDLE.
- DONE:
  - mem_busy=0, so the pipeline advances at this edge and MEM/WB captures read_data_out.
  - Go to IDLE unconditionally; the next access is never accepted in DONE.
- DRAIN:
  - mem_busy=1; wait for dm_ack; discard data; drop dm_req; go to IDLE.
  - flush is ignored.
- Latency: access seen in cycle N; request visible N+1; earliest ack N+1; result valid and stall released N+2. The minimum memory op therefore occupies 3 MEM-stage cycles.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{wdata[15:0]}}.
  - SW: be=1111, wdata unchanged.
- Load extraction:
  - B/BU: byte = dm_rdata>>(8*addr[1:0]).
  - H/HU: half = addr[1] ? upper : lower.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Uses the latched addr[1:0], not live addr_in.
- Reset mid-WAIT/DRAIN: immediate return to IDLE with dm_req=0; the memory side must tolerate an abandoned request.
- Invalid dmtype (011, 110, 111): treated as W.

Test Plan:
- LW, addr=0x100, ack one cycle after req, rdata=0xDEADBEEF:
  - dm_addr=0x100, be=1111.
  - mem_busy high 2 cycles.
  - read_data_out=0xDEADBEEF in DONE.
- LB addr=0x103 with rdata=0x80FF1234 → 0xFFFFFF80; LBU same → 0x00000080; LHU addr=0x102 → 0x000080FF.
- SH addr=0x0A, wdata=0x1234ABCD:
  - dm_we=1, be=1100, dm_wdata=0xABCDABCD, dm_addr=0x08.
  - read_data_out=0.
- LW addr=0x101 → no dm_req, misalign=1 for exactly one cycle, mem_busy never asserted.
- LW with ack delayed 5 cycles:
  - mem_busy high 6 cycles.
  - dm_req/addr stable throughout.
  - Inject flush in cycle 3 → DRAIN; ack consumed, read_data_out stays 0, return to IDLE.
- Pull rst low mid-WAIT → dm_req=0 and state IDLE immediately; after release, the next LW completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: issues one registered req/ack transaction per
// load/store, builds store byte lanes, and returns the extended load word to MEM/WB.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_rd_in,
  input  logic              mem_wr_in,
  input  logic [2:0]        dmtype_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [31:0]       wdata_in,
  input  logic              flush,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  output logic [3:0]        dm_be,
  input  logic              dm_ack,
  input  logic [31:0]       dm_rdata,
  output logic [31:0]       read_data_out,
  output logic              mem_busy,
  output logic              misalign,
  output logic [1:0]        state_dbg
);

  // Memory handshake: dm_req rises with dm_addr/dm_we/dm_be/dm_wdata and all of them stay
  // frozen until the first cycle dm_ack is seen high; that cycle completes the transfer
  // (dm_rdata sampled there) and dm_req drops at the following edge.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2, DRAIN = 2'd3} state_t;

  state_t      state, state_nxt;
  logic        access, aligned, accept, misalign_set;
  logic [1:0]  off_q;
  logic [2:0]  type_q;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt, load_val;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign access    = mem_rd_in | mem_wr_in;
  assign state_dbg = state;

  // dmtype[1:0]: 00 byte, 01 half, anything else (incl. invalid codes) is a word.
  always_comb begin
    aligned   = 1'b1;
    be_nxt    = 4'b1111;
    wdata_nxt = wdata_in;
    case (dmtype_in[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << addr_in[1:0];
        wdata_nxt = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        aligned   = ~addr_in[0];
        be_nxt    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_nxt = {2{wdata_in[15:0]}};
      end
      default: aligned = (addr_in[1:0] == 2'b00);
    endcase
  end

  assign accept       = (state == IDLE) & access & aligned & ~flush;
  assign misalign_set = (state == IDLE) & access & ~aligned & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_busy  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WAIT;
          mem_busy  = 1'b1;
        end
      end
      WAIT: begin
        mem_busy = 1'b1;
        if (dm_ack)     state_nxt = flush ? IDLE : DONE;
        else if (flush) state_nxt = DRAIN;
      end
      DONE:  state_nxt = IDLE;
      DRAIN: begin
        mem_busy = 1'b1;
        if (dm_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Extraction uses the offset/type captured at request time, not the live inputs.
  always_comb begin
    byte_sel = dm_rdata[7:0];
    case (off_q)
      2'd1:    byte_sel = dm_rdata[15:8];
      2'd2:    byte_sel = dm_rdata[23:16];
      2'd3:    byte_sel = dm_rdata[31:24];
      default: byte_sel = dm_rdata[7:0];
    endcase
    half_sel = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (type_q[1:0])
      2'b00:   load_val = {{24{byte_sel[7] & ~type_q[2]}}, byte_sel};
      2'b01:   load_val = {{16{half_sel[15] & ~type_q[2]}}, half_sel};
      default: load_val = dm_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dm_req        <= 1'b0;
      dm_we         <= 1'b0;
      dm_addr       <= '0;
      dm_wdata      <= '0;
      dm_be         <= 4'b0000;
      read_data_out <= '0;
      misalign      <= 1'b0;
      off_q         <= 2'b00;
      type_q        <= 3'b000;
    end else begin
      misalign <= misalign_set;
      case (state)
        IDLE: begin
          if (accept) begin
            dm_req   <= 1'b1;
            dm_we    <= mem_wr_in;
            dm_addr  <= {addr_in[ADDR_W-1:2], 2'b00};
            dm_be    <= be_nxt;
            dm_wdata <= wdata_nxt;
            off_q    <= addr_in[1:0];
            type_q   <= dmtype_in;
          end else if (misalign_set) begin
            read_data_out <= '0;
          end
        end
        WAIT: begin
          if (dm_ack) begin
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            read_data_out <= (flush | dm_we) ? 32'h0 : load_val;
          end
        end
        DRAIN: begin
          if (dm_ack) begin
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            read_data_out <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random loads/stores against a
// transaction-level model of lane selection, extension and stall length.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rd_in = 1'b0, mem_wr_in = 1'b0, flush = 1'b0;
  logic [2:0]  dmtype_in = 3'b010;
  logic [31:0] addr_in = '0, wdata_in = '0;
  logic        dm_req, dm_we, dm_ack = 1'b0, mem_busy, misalign;
  logic [31:0] dm_addr, dm_wdata, dm_rdata = '0, read_data_out;
  logic [3:0]  dm_be;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2, S_DRAIN = 2'd3;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in), .dmtype_in(dmtype_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .flush(flush),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .read_data_out(read_data_out), .mem_busy(mem_busy), .misalign(misalign),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // size: 0 byte, 1 half, 2 word (invalid codes behave as word)
  function automatic int size_of(input logic [2:0] t);
    if (t == 3'b000 || t == 3'b100) return 0;
    if (t == 3'b001 || t == 3'b101) return 1;
    return 2;
  endfunction

  function automatic bit is_aligned(input logic [2:0] t, input logic [31:0] a);
    int s = size_of(t);
    if (s == 0) return 1'b1;
    if (s == 1) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] t, input logic [31:0] a);
    int s = size_of(t);
    if (s == 0) return 4'(1 << (a % 4));
    if (s == 1) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] t, input logic [31:0] w);
    int s = size_of(t);
    if (s == 0) return (w & 32'hFF) * 32'h0101_0101;
    if (s == 1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] r);
    logic [31:0] v;
    int s = size_of(t);
    if (s == 2) return r;
    v = r >> (8 * (a % 4));
    if (s == 0) begin
      v = v & 32'hFF;
      if (t == 3'b000 && v >= 32'd128) v = v - 32'd256;
    end else begin
      v = v & 32'hFFFF;
      if (t == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic idle_cycle();
    @(negedge clk);
    mem_rd_in = 1'b0; mem_wr_in = 1'b0; flush = 1'b0; dm_ack = 1'b0;
  endtask

  // flush_at: -1 none, 0 flush in the accept cycle, k>0 flush in k-th wait cycle.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                        input int ack_delay, input int flush_at);
    int busy_n;
    bit al, mis;
    al  = is_aligned(t, a);
    mis = !al && flush_at != 0;
    @(negedge clk);
    mem_rd_in = rd; mem_wr_in = wr; dmtype_in = t; addr_in = a; wdata_in = wd;
    dm_ack = 1'b0; flush = (flush_at == 0);
    #1;
    if (flush_at == 0 || !al) begin
      check("busy_noacc", mem_busy, 1'b0);
      @(negedge clk);
      mem_rd_in = 1'b0; mem_wr_in = 1'b0; flush = 1'b0;
      check("noacc_req", dm_req, 1'b0);
      check("noacc_state", state_dbg, S_IDLE);
      check("misalign_set", misalign, mis);
      if (mis) check("misalign_rdata", read_data_out, 32'h0);
      #1 check("misalign_busy", mem_busy, 1'b0);
      @(negedge clk);
      check("misalign_clr", misalign, 1'b0);
      return;
    end
    check("busy_accept", mem_busy, 1'b1);
    busy_n = 1;
    for (int k = 1; k <= ack_delay; k++) begin
      @(negedge clk);
      check("req", dm_req, 1'b1);
      check("we", dm_we, wr);
      check("addr", dm_addr, a & 32'hFFFF_FFFC);
      check("be", dm_be, exp_be(t, a));
      check("wdata", dm_wdata, exp_wdata(t, wd));
      check("wait_state", state_dbg, (flush_at > 0 && k > flush_at) ? S_DRAIN : S_WAIT);
      flush = (k == flush_at);
      if (k == flush_at) begin
        mem_rd_in = 1'b0; mem_wr_in = 1'b0;
      end
      dm_ack   = (k == ack_delay);
      dm_rdata = dm_ack ? rdat : $urandom;
      #1;
      if (mem_busy) busy_n++;
    end
    @(negedge clk);
    dm_ack = 1'b0; flush = 1'b0; dm_rdata = $urandom;
    check("busy_count", busy_n, ack_delay + 1);
    check("req_drop", dm_req, 1'b0);
    check("we_drop", dm_we, 1'b0);
    if (flush_at > 0) begin
      check("flush_state", state_dbg, S_IDLE);
      check("flush_rdata", read_data_out, 32'h0);
    end else begin
      check("done_state", state_dbg, S_DONE);
      check("load_data", read_data_out, wr ? 32'h0 : exp_load(t, a, rdat));
    end
    #1 check("busy_release", mem_busy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] types [8];
    types = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    repeat (2) @(negedge clk);
    check("rst_req", dm_req, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_we", dm_we, 1'b0);
    check("rst_addr", dm_addr, 32'h0);
    check("rst_wdata", dm_wdata, 32'h0);
    check("rst_be", dm_be, 4'h0);
    check("rst_rdata", read_data_out, 32'h0);
    check("rst_misalign", misalign, 1'b0);
    check("rst_state", state_dbg, S_IDLE);
    check("rst_busy", mem_busy, 1'b0);

    run_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1, -1);
    run_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 1, -1);
    run_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 2, -1);
    run_op(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 1, -1);
    run_op(0, 1, 3'b001, 32'h0A, 32'h1234ABCD, 32'h5555AAAA, 1, -1);
    run_op(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 1, -1);
    run_op(1, 0, 3'b010, 32'h200, 32'h0, 32'hCAFEF00D, 5, -1);
    run_op(1, 0, 3'b010, 32'h204, 32'h0, 32'h12345678, 5, 3);
    run_op(1, 0, 3'b001, 32'h206, 32'h0, 32'h0000FFFF, 3, 3);
    run_op(1, 0, 3'b010, 32'h300, 32'h0, 32'h0, 1, 0);

    // asynchronous reset while a request is outstanding
    @(negedge clk);
    mem_rd_in = 1'b1; dmtype_in = 3'b010; addr_in = 32'h400; flush = 1'b0; dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_req", dm_req, 1'b1);
    mem_rd_in = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_req", dm_req, 1'b0);
    check("midrst_state", state_dbg, S_IDLE);
    check("midrst_busy", mem_busy, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    run_op(1, 0, 3'b010, 32'h404, 32'h0, 32'h0BADF00D, 2, -1);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] t;
      logic [31:0] a;
      logic wr;
      int dly, fl;
      t  = types[$urandom_range(0, 7)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (size_of(t) == 1) a = a & 32'hFFFF_FFFE;
        if (size_of(t) == 2) a = a & 32'hFFFF_FFFC;
      end
      wr  = (t == 3'b000 || t == 3'b001 || t == 3'b010) && $urandom_range(0, 1) == 1;
      dly = $urandom_range(1, 6);
      fl  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, dly)) : -1;
      run_op(!wr, wr, t, a, $urandom, $urandom, dly, fl);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    idle_cycle();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
